// File: rtl/div_seq_restoring_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The requester drives start/A/B; the divider returns status and results.
interface div_seq_restoring_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/div_seq_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH-cycle
// latency, start/busy/done handshake. Divide by zero completes in one cycle.
module div_seq_restoring #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  div_seq_restoring_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH:0]   p_reg, p_next;
  logic             zero_pend_reg, zero_pend_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             dbz_reg, dbz_next;
  logic             accept;

  // Trial subtraction: the extra top bit of diff is the borrow.
  logic [WIDTH:0]   p_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   p_trial;
  logic [WIDTH-1:0] dvd_shift;

  assign p_sh      = {p_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign diff      = {1'b0, p_sh} - {2'b00, dvs_reg};
  assign borrow    = diff[WIDTH+1];
  assign p_trial   = borrow ? p_sh : diff[WIDTH:0];
  assign dvd_shift = {dvd_reg[WIDTH-2:0], ~borrow};

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    p_next         = p_reg;
    zero_pend_next = zero_pend_reg;
    done_next      = 1'b0;
    q_next         = q_reg;
    r_next         = r_reg;
    dbz_next       = dbz_reg;
    accept         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) accept = 1'b1;
      end
      RUN: begin
        p_next   = p_trial;
        dvd_next = dvd_shift;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
          done_next  = 1'b1;
          q_next     = dvd_shift;
          r_next     = p_trial[WIDTH-1:0];
          dbz_next   = 1'b0;
        end
      end
      DONE: begin
        // A zero-divisor request spends one quiet cycle here before reporting.
        if (zero_pend_reg) begin
          zero_pend_next = 1'b0;
          done_next      = 1'b1;
          q_next         = '1;
          r_next         = dvd_reg;
          dbz_next       = 1'b1;
        end else if (bus.start) begin
          accept = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      dvd_next = bus.A;
      dvs_next = bus.B;
      p_next   = '0;
      cnt_next = CW'(WIDTH);
      if (bus.B != '0) begin
        state_next = RUN;
      end else begin
        state_next     = DONE;
        zero_pend_next = 1'b1;
      end
    end

    busy_next = (state_next == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      p_reg         <= '0;
      zero_pend_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      q_reg         <= '0;
      r_reg         <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      p_reg         <= p_next;
      zero_pend_reg <= zero_pend_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      q_reg         <= q_next;
      r_reg         <= r_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.Q           = q_reg;
  assign bus.R           = r_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring (WIDTH=8): directed table, corner
// sequences, and random operands against a plain-arithmetic reference.
module tb_div_seq_restoring;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_restoring_if #(.WIDTH(W)) dif();
  div_seq_restoring #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(dif));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dbz);
    if (b == 0) begin
      q = 8'hFF; r = a; dbz = 1'b1;
    end else begin
      q = a / b; r = a % b; dbz = 1'b0;
    end
  endfunction

  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (!dif.done && lat < 20) begin
      if (dif.busy) bcnt++;
      step();
      lat++;
    end
  endtask

  // Accepts on the next edge, then scrambles operands to prove they were latched.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
    dif.start = 1'b1;
    dif.A     = a;
    dif.B     = b;
    step();
    dif.start = 1'b0;
    dif.A     = 8'($urandom);
    dif.B     = 8'($urandom);
    wait_done(0, lat, bcnt);
  endtask

  task automatic check_after(input string name, input logic [7:0] q_exp, input logic [7:0] r_exp);
    step();
    chk({name, "_done_drop"}, 32'(dif.done), 0);
    chk({name, "_q_held"}, 32'(dif.Q), 32'(q_exp));
    chk({name, "_r_held"}, 32'(dif.R), 32'(r_exp));
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [7:0] a, b, q_exp, r_exp;
    logic dbz_exp;

    vecs[0] = '{a:8'd200, b:8'd7,   q:8'd28,  r:8'd4,   dbz:1'b0, lat:8};
    vecs[1] = '{a:8'd255, b:8'd1,   q:8'd255, r:8'd0,   dbz:1'b0, lat:8};
    vecs[2] = '{a:8'd5,   b:8'd9,   q:8'd0,   r:8'd5,   dbz:1'b0, lat:8};
    vecs[3] = '{a:8'd0,   b:8'd3,   q:8'd0,   r:8'd0,   dbz:1'b0, lat:8};
    vecs[4] = '{a:8'd255, b:8'd255, q:8'd1,   r:8'd0,   dbz:1'b0, lat:8};
    vecs[5] = '{a:8'd100, b:8'd0,   q:8'd255, r:8'd100, dbz:1'b1, lat:1};
    vecs[6] = '{a:8'd9,   b:8'd2,   q:8'd4,   r:8'd1,   dbz:1'b0, lat:8};

    dif.start = 1'b0;
    dif.A     = '0;
    dif.B     = '0;
    rst       = 1'b1;
    repeat (3) step();
    chk("rst_busy", 32'(dif.busy), 0);
    chk("rst_done", 32'(dif.done), 0);
    chk("rst_q", 32'(dif.Q), 0);
    chk("rst_r", 32'(dif.R), 0);
    chk("rst_dbz", 32'(dif.div_by_zero), 0);
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat, bcnt);
      $display("txn vec%0d %0d/%0d -> Q=%0d R=%0d dbz=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, dif.Q, dif.R, dif.div_by_zero, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busycnt", i), 32'(bcnt), (vecs[i].b != 0) ? 32'(W) : 32'd0);
      chk($sformatf("vec%0d_busy_at_done", i), 32'(dif.busy), 0);
      chk($sformatf("vec%0d_q", i), 32'(dif.Q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), 32'(dif.R), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(dif.div_by_zero), 32'(vecs[i].dbz));
      check_after($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
    end

    // Start while busy is ignored; operands change mid-run
    dif.start = 1'b1; dif.A = 8'd13; dif.B = 8'd3;
    step();
    dif.start = 1'b0;
    step();
    step();
    dif.start = 1'b1; dif.A = 8'd50; dif.B = 8'd5;
    step();
    dif.start = 1'b0; dif.A = 8'd77; dif.B = 8'd1;
    wait_done(3, lat, bcnt);
    $display("txn ignore 13/3 -> Q=%0d R=%0d lat=%0d", dif.Q, dif.R, lat);
    chk("ign_lat", 32'(lat), 8);
    chk("ign_q", 32'(dif.Q), 4);
    chk("ign_r", 32'(dif.R), 1);
    check_after("ign", 8'd4, 8'd1);
    step();
    chk("ign_no_second_busy", 32'(dif.busy), 0);

    // Reset in the middle of a divide
    dif.start = 1'b1; dif.A = 8'd200; dif.B = 8'd7;
    step();
    dif.start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(dif.busy), 0);
    chk("midrst_done", 32'(dif.done), 0);
    chk("midrst_q", 32'(dif.Q), 0);
    chk("midrst_r", 32'(dif.R), 0);
    chk("midrst_dbz", 32'(dif.div_by_zero), 0);
    seen = 0;
    repeat (12) begin
      if (dif.done || dif.busy) seen = 1;
      step();
    end
    chk("midrst_quiet", 32'(seen), 0);
    run_div(8'd17, 8'd4, lat, bcnt);
    $display("txn after_rst 17/4 -> Q=%0d R=%0d lat=%0d", dif.Q, dif.R, lat);
    chk("postrst_lat", 32'(lat), 8);
    chk("postrst_q", 32'(dif.Q), 4);
    chk("postrst_r", 32'(dif.R), 1);
    step();

    // Back-to-back: start held through the done cycle
    dif.start = 1'b1; dif.A = 8'd200; dif.B = 8'd7;
    step();
    dif.start = 1'b0;
    repeat (7) step();
    chk("b2b_not_early", 32'(dif.done), 0);
    dif.start = 1'b1; dif.A = 8'd81; dif.B = 8'd9;
    step();
    chk("b2b_first_done", 32'(dif.done), 1);
    chk("b2b_first_q", 32'(dif.Q), 28);
    chk("b2b_first_r", 32'(dif.R), 4);
    step();
    dif.start = 1'b0;
    chk("b2b_done_drop", 32'(dif.done), 0);
    chk("b2b_busy", 32'(dif.busy), 1);
    wait_done(0, lat, bcnt);
    $display("txn b2b 81/9 -> Q=%0d R=%0d lat=%0d", dif.Q, dif.R, lat);
    chk("b2b_second_lat", 32'(lat), 8);
    chk("b2b_second_q", 32'(dif.Q), 9);
    chk("b2b_second_r", 32'(dif.R), 0);
    step();

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      ref_div(a, b, q_exp, r_exp, dbz_exp);
      run_div(a, b, lat, bcnt);
      $display("txn rnd%0d %0d/%0d -> Q=%0d R=%0d dbz=%0d lat=%0d",
               i, a, b, dif.Q, dif.R, dif.div_by_zero, lat);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), (b != 0) ? 32'(W) : 32'd1);
      chk($sformatf("rnd%0d_q", i), 32'(dif.Q), 32'(q_exp));
      chk($sformatf("rnd%0d_r", i), 32'(dif.R), 32'(r_exp));
      chk($sformatf("rnd%0d_dbz", i), 32'(dif.div_by_zero), 32'(dbz_exp));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
